// File: rtl/adder_et_checker_pkg.sv
// Shared types and sizing helpers for the approximate-adder error-threshold checker.
package adder_et_checker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 2;

    // Error counter must hold 2^(2*in_w) itself, hence one extra bit.
    function automatic int unsigned cnt_w(input int unsigned in_w);
        return 2 * in_w + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned out_w);
        return out_w + 2 * in_w;
    endfunction

endpackage

// File: rtl/adder_abs_err.sv
// Exact-sum generator (stage 1) and unsigned absolute-difference unit (stage 2).
module adder_abs_err #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = IN_W + 1
) (
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic [OUT_W-1:0] exact_i,
    input  logic [OUT_W-1:0] sum_i,
    output logic [OUT_W-1:0] exact_o,
    output logic [OUT_W-1:0] abs_err_o
);

    always_comb begin
        exact_o   = OUT_W'(a_i) + OUT_W'(b_i);
        abs_err_o = (exact_i >= sum_i) ? (exact_i - sum_i) : (sum_i - exact_i);
    end

endmodule

// File: rtl/adder_et_checker.sv
// Exhaustive sweep checker for a combinational approximate adder; reports error stats and verdict.
// Optional first-violation capture is enabled by defining ADDER_ET_CHECKER_FIRST_FAIL_EN.
module adder_et_checker
    import adder_et_checker_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = IN_W + 1,
    parameter int unsigned ET    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [2*IN_W-1:0]                stim,
    input  logic [OUT_W-1:0]                 dut_sum,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [OUT_W-1:0]                 max_err,
    output logic [cnt_w(IN_W)-1:0]           err_count,
    output logic [sum_w(IN_W, OUT_W)-1:0]    sum_abs_err,
    output logic                             fail_seen,
    output logic [2*IN_W-1:0]                fail_vec
);

    localparam int unsigned SW = 2 * IN_W;
    localparam int unsigned CW = cnt_w(IN_W);
    localparam int unsigned AW = sum_w(IN_W, OUT_W);
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [SW-1:0]    LastVec   = '1;
    localparam logic [DW-1:0]    DrainLast = DW'(DRAIN_CYCLES - 1);
    localparam logic [OUT_W-1:0] EtVal     = OUT_W'(ET);

    state_e            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              clear, last_drain;

    logic              s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]  s1_exact_q, s1_exact_d;
    logic [OUT_W-1:0]  s1_sum_q, s1_sum_d;

    logic [OUT_W-1:0]  max_err_q, max_err_d;
    logic [CW-1:0]     err_cnt_q, err_cnt_d;
    logic [AW-1:0]     sum_err_q, sum_err_d;
    logic              pass_q, pass_d;

    logic [OUT_W-1:0]  exact, abs_err;

    adder_abs_err #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_abs_err (
        .a_i       (cnt_q[IN_W-1:0]),
        .b_i       (cnt_q[SW-1:IN_W]),
        .exact_i   (s1_exact_q),
        .sum_i     (s1_sum_q),
        .exact_o   (exact),
        .abs_err_o (abs_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        clear      = 1'b0;
        last_drain = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StSweep: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastVec) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DrainLast) begin
                    state_d    = StDone;
                    last_drain = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 1 captures the vector in flight; stage 2 folds its error into the accumulators.
    always_comb begin
        s1_valid_d = (state_q == StSweep);
        s1_exact_d = exact;
        s1_sum_d   = dut_sum;
        max_err_d  = max_err_q;
        err_cnt_d  = err_cnt_q;
        sum_err_d  = sum_err_q;
        pass_d     = pass_q;
        if (clear) begin
            max_err_d = '0;
            err_cnt_d = '0;
            sum_err_d = '0;
            pass_d    = 1'b0;
        end else if (s1_valid_q) begin
            if (abs_err > max_err_q) max_err_d = abs_err;
            err_cnt_d = err_cnt_q + CW'(abs_err != '0);
            sum_err_d = sum_err_q + AW'(abs_err);
        end
        if (last_drain) pass_d = (max_err_q <= EtVal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            drain_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_exact_q <= '0;
            s1_sum_q   <= '0;
            max_err_q  <= '0;
            err_cnt_q  <= '0;
            sum_err_q  <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            s1_exact_q <= s1_exact_d;
            s1_sum_q   <= s1_sum_d;
            max_err_q  <= max_err_d;
            err_cnt_q  <= err_cnt_d;
            sum_err_q  <= sum_err_d;
            pass_q     <= pass_d;
        end
    end

`ifdef ADDER_ET_CHECKER_FIRST_FAIL_EN
    logic [SW-1:0] s1_stim_q;
    logic          fail_seen_q, fail_seen_d;
    logic [SW-1:0] fail_vec_q, fail_vec_d;

    always_comb begin
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        if (clear) begin
            fail_seen_d = 1'b0;
            fail_vec_d  = '0;
        end else if (s1_valid_q && !fail_seen_q && (abs_err > EtVal)) begin
            fail_seen_d = 1'b1;
            fail_vec_d  = s1_stim_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_stim_q   <= '0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
        end else begin
            s1_stim_q   <= cnt_q;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign fail_seen = fail_seen_q;
    assign fail_vec  = fail_vec_q;
`else
    assign fail_seen = 1'b0;
    assign fail_vec  = '0;
`endif

    assign stim        = cnt_q;
    assign busy        = (state_q == StSweep) || (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign pass        = pass_q;
    assign max_err     = max_err_q;
    assign err_count   = err_cnt_q;
    assign sum_abs_err = sum_err_q;

endmodule

// File: tb/tb_adder_et_checker.sv
// Directed bench for adder_et_checker with a behavioural approximate adder (exact, stuck-0, +1).
module tb_adder_et_checker;

    localparam int IN_W  = 2;
    localparam int OUT_W = 3;
    localparam int N     = 16;
`ifdef ADDER_ET_CHECKER_FIRST_FAIL_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       stim;
    logic [2:0]       dut_sum;
    logic             busy, done, pass;
    logic [2:0]       max_err;
    logic [4:0]       err_count;
    logic [6:0]       sum_abs_err;
    logic             fail_seen;
    logic [3:0]       fail_vec;

    int mode = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: exact adder, 1: output stuck at zero, 2: exact sum plus one
    always_comb begin
        case (mode)
            1:       dut_sum = 3'd0;
            2:       dut_sum = 3'(stim[1:0]) + 3'(stim[3:2]) + 3'd1;
            default: dut_sum = 3'(stim[1:0]) + 3'(stim[3:2]);
        endcase
    end

    adder_et_checker #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stim        (stim),
        .dut_sum     (dut_sum),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .max_err     (max_err),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .fail_seen   (fail_seen),
        .fail_vec    (fail_vec)
    );

    // Start at edge 0, then observe cycles 1..30 at the falling edge.
    task automatic sweep(input bit pulses, output int done_cyc, output int done_n,
                         output bit busy_ok);
        done_cyc = -1;
        done_n   = 0;
        busy_ok  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = pulses && (cyc == 5 || cyc == 10);
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy !== (cyc <= N + 2)) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [28:0] all_out;
        #2;
        all_out = {stim, busy, done, pass, max_err, err_count, sum_abs_err, fail_seen, fail_vec};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        all_out = {stim, busy, done, pass, max_err, err_count, sum_abs_err, fail_seen, fail_vec};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_after_reset got=%h want=0", all_out);
        end
    endtask

    task automatic test_exact;
        int dc, dn; bit bo;
        mode = 0;
        sweep(1'b0, dc, dn, bo);
        checks++; if (dc !== 19) begin errors++; $display("FAIL exact_done_cycle got=%0d want=19", dc); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL exact_busy_window got=%0d want=1", bo); end
        checks++; if (max_err !== 3'd0) begin errors++; $display("FAIL exact_max_err got=%0d want=0", max_err); end
        checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL exact_err_count got=%0d want=0", err_count); end
        checks++; if (sum_abs_err !== 7'd0) begin errors++; $display("FAIL exact_sum_abs got=%0d want=0", sum_abs_err); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL exact_pass got=%0d want=1", pass); end
        checks++; if (fail_seen !== 1'b0) begin errors++; $display("FAIL exact_fail_seen got=%0d want=0", fail_seen); end
    endtask

    task automatic test_stuck_zero;
        int dc, dn; bit bo;
        mode = 1;
        sweep(1'b0, dc, dn, bo);
        checks++; if (dc !== 19) begin errors++; $display("FAIL stuck_done_cycle got=%0d want=19", dc); end
        checks++; if (max_err !== 3'd6) begin errors++; $display("FAIL stuck_max_err got=%0d want=6", max_err); end
        checks++; if (err_count !== 5'd15) begin errors++; $display("FAIL stuck_err_count got=%0d want=15", err_count); end
        checks++; if (sum_abs_err !== 7'd48) begin errors++; $display("FAIL stuck_sum_abs got=%0d want=48", sum_abs_err); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got=%0d want=0", pass); end
        checks++; if (fail_seen !== FF) begin errors++; $display("FAIL stuck_fail_seen got=%0d want=%0d", fail_seen, FF); end
        checks++; if (fail_vec !== (FF ? 4'd3 : 4'd0)) begin
            errors++; $display("FAIL stuck_fail_vec got=%0d want=%0d", fail_vec, FF ? 3 : 0);
        end
    endtask

    task automatic test_plus_one(input bit pulses);
        int dc, dn; bit bo;
        mode = 2;
        sweep(pulses, dc, dn, bo);
        checks++; if (dc !== 19) begin errors++; $display("FAIL plus1_done_cycle p=%0d got=%0d want=19", pulses, dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL plus1_done_count p=%0d got=%0d want=1", pulses, dn); end
        checks++; if (max_err !== 3'd1) begin errors++; $display("FAIL plus1_max_err p=%0d got=%0d want=1", pulses, max_err); end
        checks++; if (err_count !== 5'd16) begin errors++; $display("FAIL plus1_err_count p=%0d got=%0d want=16", pulses, err_count); end
        checks++; if (sum_abs_err !== 7'd16) begin errors++; $display("FAIL plus1_sum_abs p=%0d got=%0d want=16", pulses, sum_abs_err); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL plus1_pass p=%0d got=%0d want=1", pulses, pass); end
        checks++; if (fail_seen !== 1'b0) begin errors++; $display("FAIL plus1_fail_seen p=%0d got=%0d want=0", pulses, fail_seen); end
    endtask

    task automatic test_reset_mid_sweep;
        int dc, dn; bit bo;
        logic [28:0] all_out;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 8) begin
                rst_n = 1'b0;
                #1;
                all_out = {stim, busy, done, pass, max_err, err_count, sum_abs_err, fail_seen, fail_vec};
                checks++;
                if (all_out !== '0) begin
                    errors++; $display("FAIL midreset_outputs got=%h want=0", all_out);
                end
            end
            if (cyc == 10) rst_n = 1'b1;
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, stim} !== '0) begin
            errors++; $display("FAIL midreset_idle got=%h want=0", {busy, done, stim});
        end
        mode = 0;
        sweep(1'b0, dc, dn, bo);
        checks++; if (dc !== 19) begin errors++; $display("FAIL midreset_done_cycle got=%0d want=19", dc); end
        checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL midreset_err_count got=%0d want=0", err_count); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL midreset_pass got=%0d want=1", pass); end
    endtask

    task automatic test_back_to_back;
        int dc2 = -1;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 2 * N + 12; cyc++) begin
            @(negedge clk);
            if (cyc == N + 3) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%0d want=1", done); end
                checks++; if (max_err !== 3'd6) begin errors++; $display("FAIL b2b_first_max got=%0d want=6", max_err); end
                mode = 2;
            end
            if (cyc == N + 4) begin
                start = 1'b0;
                checks++; if (stim !== 4'd0) begin errors++; $display("FAIL b2b_stim got=%0d want=0", stim); end
                checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_busy_done got=%b want=10", {busy, done}); end
                checks++;
                if ({max_err, err_count, sum_abs_err} !== '0) begin
                    errors++; $display("FAIL b2b_cleared got=%h want=0", {max_err, err_count, sum_abs_err});
                end
            end
            if (cyc > N + 4 && done && dc2 < 0) dc2 = cyc;
        end
        start = 1'b0;
        checks++; if (dc2 !== 2 * (N + 3)) begin errors++; $display("FAIL b2b_second_done got=%0d want=%0d", dc2, 2 * (N + 3)); end
        checks++; if (err_count !== 5'd16) begin errors++; $display("FAIL b2b_second_count got=%0d want=16", err_count); end
        checks++; if (max_err !== 3'd1) begin errors++; $display("FAIL b2b_second_max got=%0d want=1", max_err); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_stuck_zero();
        test_plus_one(1'b0);
        test_plus_one(1'b1);
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_et_checker.md
# adder_et_checker

Sequential error-threshold checker that closes the loop on a generated approximate adder netlist. It drives an exhaustive operand sweep onto the combinational approximate adder's inputs and compares each returned sum against the exact sum. It accumulates maximum absolute error, error count and total absolute error, then issues a pass/fail verdict against the error threshold ET. It sits beside each synthesized `adder_i*_o*` variant in hardware-in-the-loop validation of the approximation flow.

## Interface
Parameters:
- `IN_W`, 2, width of each operand; stimulus is 2*IN_W bits.
- `OUT_W`, IN_W+1, width of the adder sum returned by the DUT.
- `ET`, 2, maximum permitted absolute error (unsigned, OUT_W bits).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request; sampled only in IDLE or DONE.
- `stim` out 2*IN_W: operand vector to DUT inputs in0..in(2*IN_W-1); a = stim[IN_W-1:0], b = stim[2*IN_W-1:IN_W].
- `dut_sum` in OUT_W: DUT outputs out0..out(OUT_W-1), combinational response to `stim`.
- `busy` out 1: sweep or drain in progress.
- `done` out 1: one-cycle pulse; results valid.
- `pass` out 1: max_err <= ET.
- `max_err` out OUT_W: largest |exact - dut_sum|.
- `err_count` out 2*IN_W+1: vectors with nonzero error.
- `sum_abs_err` out OUT_W+2*IN_W: sum of |exact - dut_sum| over all vectors.
- `fail_seen` out 1, `fail_vec` out 2*IN_W: first-violation capture (see Configuration).

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start: go to SWEEP, clear vector counter, max_err, err_count, sum_abs_err, pass, fail_seen, fail_vec.
- SWEEP: stim = counter, counter increments each cycle; after vector 2^(2*IN_W)-1, go to DRAIN.
- DRAIN: 2 cycles for pipeline flush, then DONE.
- DONE: 1 cycle, done=1. Next state is IDLE, or SWEEP if start=1.
- start is ignored in SWEEP/DRAIN.
- Stage 1 registers stim, dut_sum and exact = a+b. exact is zero-extended to OUT_W; the carry is kept.
- Stage 2 computes abs_err = |exact - dut_sum| as an unsigned OUT_W difference, larger minus smaller. It then updates max_err, err_count (+1 if abs_err != 0) and sum_abs_err (+abs_err).
- Accumulators are sized not to overflow; no saturation or wrap is needed.
- pass is registered in the last DRAIN cycle. It and all results hold until the next accepted start.
- Reset values: stim=0, busy=0, done=0, pass=0, max_err=0, err_count=0, sum_abs_err=0, fail_seen=0, fail_vec=0, state IDLE.
- rst_n low mid-sweep aborts immediately to reset values; no partial results are retained.

## Timing
- Cycle 0 = edge sampling start. Let N = 2^(2*IN_W).
- Vector v is presented during cycle 1+v. dut_sum is sampled at the end of that cycle.
- busy is high in cycles 1..N+2.
- done is high in cycle N+3 only; N=16 gives cycle 19.
- A back-to-back start in the done cycle gives stim=0 in cycle N+4.
- The DUT is purely combinational with a single-cycle path; no DUT handshake.

## Configuration
- `ADDER_ET_CHECKER_FIRST_FAIL_EN` defined:
  - on the first vector with abs_err > ET, set fail_seen=1 and capture that vector's stim into fail_vec;
  - later violations do not overwrite until the next start.
- Undefined: fail_seen and fail_vec are tied to 0, and the capture logic is absent.

## Structure
- `adder_et_checker_pkg`: FSM state enum, DRAIN_CYCLES=2 constant, width helper functions for the accumulators.
- One sub-module, `adder_abs_err`: combinational exact-sum and absolute-difference unit used by stage 1/2.

## Test plan
- Exact model (dut_sum=a+b), IN_W=2, ET=2 → done in cycle 19, max_err=0, err_count=0, sum_abs_err=0, pass=1.
- dut_sum stuck at 0 → max_err=6, err_count=15, sum_abs_err=48, pass=0; with FIRST_FAIL_EN: fail_seen=1, fail_vec=3.
- dut_sum=a+b+1 → max_err=1, err_count=16, sum_abs_err=16, pass=1, fail_seen=0.
- start pulsed in cycles 5 and 10 during SWEEP → ignored; single done in cycle 19, results unchanged.
- rst_n low in cycle 8, released in cycle 10 → all outputs at reset values, state IDLE. A new start then gives done 19 cycles later with correct results.
- start held through the done cycle → second sweep begins; accumulators clear in cycle N+4.
